// File: rtl/instr_buffer.sv
// Per-warp instruction buffer: 8 circular FIFOs fed by two decode slots, one lowest-index pop per cycle.
// Issue latency is 1 cycle with no backpressure; full-warp writes are dropped and flagged on Overflow_IB.
module instr_buffer #(
  parameter int DEPTH = 4,
  parameter int DEC_W = 45
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      Instr_ID0_IB,
  input  logic [31:0]      Instr_ID1_IB,
  input  logic [DEC_W-1:0] Dec_ID0_IB,
  input  logic [DEC_W-1:0] Dec_ID1_IB,
  input  logic [7:0]       Valid_ID0_IB,
  input  logic [7:0]       Valid_ID1_IB,
  input  logic [7:0]       Valid_IF_ID0_IB,
  input  logic [7:0]       Valid_IF_ID1_IB,
  input  logic [7:0]       Flush_IB,
  input  logic [7:0]       Issue_Sched_IB,
  output logic [7:0]       Req_IB_PC,
  output logic [7:0]       HeadValid_IB_Sched,
  output logic             Valid_IB_OC,
  output logic [2:0]       WarpID_IB_OC,
  output logic [31:0]      Instr_IB_OC,
  output logic [DEC_W-1:0] Dec_IB_OC,
  output logic             Overflow_IB
);

  localparam int NW = 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 2;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]    rd_ptr_q [NW];
  logic [PW-1:0]    rd_ptr_d [NW];
  logic [PW-1:0]    wr_ptr_q [NW];
  logic [PW-1:0]    wr_ptr_d [NW];
  logic [CW-1:0]    cnt_q    [NW];
  logic [CW-1:0]    cnt_d    [NW];
  logic [31:0]      instr_mem_q [NW][DEPTH];
  logic [31:0]      instr_mem_d [NW][DEPTH];
  logic [DEC_W-1:0] dec_mem_q   [NW][DEPTH];
  logic [DEC_W-1:0] dec_mem_d   [NW][DEPTH];

  logic             valid_oc_q, valid_oc_d;
  logic [2:0]       warp_oc_q, warp_oc_d;
  logic [31:0]      instr_oc_q, instr_oc_d;
  logic [DEC_W-1:0] dec_oc_q, dec_oc_d;
  logic             overflow_q, overflow_d;

  logic [2:0] pop_w, w0, w1;
  logic       pop_ok, dup, wr0_try, wr1_try, room0, room1, wr0_ok, wr1_ok;

  function automatic logic [2:0] low_idx(input logic [7:0] v);
    low_idx = '0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (v[i]) low_idx = 3'(i);
    end
  endfunction

  // A full warp still accepts a write when the same warp is popped this cycle.
  always_comb begin
    pop_w   = low_idx(Issue_Sched_IB);
    pop_ok  = (|Issue_Sched_IB) && (cnt_q[pop_w] != '0) && !Flush_IB[pop_w];
    w0      = low_idx(Valid_ID0_IB);
    w1      = low_idx(Valid_ID1_IB);
    dup     = (|Valid_ID0_IB) && (|Valid_ID1_IB) && (w0 == w1);
    wr0_try = (|Valid_ID0_IB) && !Flush_IB[w0];
    wr1_try = (|Valid_ID1_IB) && !Flush_IB[w1] && !dup;
    room0   = (cnt_q[w0] < FULL) || (pop_ok && (pop_w == w0));
    room1   = (cnt_q[w1] < FULL) || (pop_ok && (pop_w == w1));
    wr0_ok  = wr0_try && room0;
    wr1_ok  = wr1_try && room1;
    overflow_d = overflow_q || dup || (wr0_try && !room0) || (wr1_try && !room1);
  end

  always_comb begin
    logic push0, push1, pop;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    instr_mem_d = instr_mem_q;
    dec_mem_d   = dec_mem_q;
    for (int w = 0; w < NW; w++) begin
      push0 = wr0_ok && (w0 == 3'(w));
      push1 = wr1_ok && (w1 == 3'(w));
      pop   = pop_ok && (pop_w == 3'(w));
      if (Flush_IB[w]) begin
        rd_ptr_d[w] = '0;
        wr_ptr_d[w] = '0;
        cnt_d[w]    = '0;
      end else begin
        if (push0) begin
          instr_mem_d[w][wr_ptr_q[w]] = Instr_ID0_IB;
          dec_mem_d[w][wr_ptr_q[w]]   = Dec_ID0_IB;
        end else if (push1) begin
          instr_mem_d[w][wr_ptr_q[w]] = Instr_ID1_IB;
          dec_mem_d[w][wr_ptr_q[w]]   = Dec_ID1_IB;
        end
        if (push0 || push1) wr_ptr_d[w] = wr_ptr_q[w] + PW'(1);
        if (pop)            rd_ptr_d[w] = rd_ptr_q[w] + PW'(1);
        if ((push0 || push1) && !pop)      cnt_d[w] = cnt_q[w] + CW'(1);
        else if (pop && !(push0 || push1)) cnt_d[w] = cnt_q[w] - CW'(1);
      end
    end
  end

  // Issued data holds its last value when nothing pops.
  always_comb begin
    valid_oc_d = pop_ok;
    warp_oc_d  = warp_oc_q;
    instr_oc_d = instr_oc_q;
    dec_oc_d   = dec_oc_q;
    if (pop_ok) begin
      warp_oc_d  = pop_w;
      instr_oc_d = instr_mem_q[pop_w][rd_ptr_q[pop_w]];
      dec_oc_d   = dec_mem_q[pop_w][rd_ptr_q[pop_w]];
    end
  end

  // One spare slot is held back for an instruction granted at PC but not yet in flight.
  always_comb begin
    logic [SW-1:0] sum;
    Req_IB_PC          = '0;
    HeadValid_IB_Sched = '0;
    for (int w = 0; w < NW; w++) begin
      sum = SW'(cnt_q[w]) + SW'(Valid_IF_ID0_IB[w]) + SW'(Valid_IF_ID1_IB[w])
          + SW'(Valid_ID0_IB[w]) + SW'(Valid_ID1_IB[w]);
      Req_IB_PC[w]          = !Flush_IB[w] && (sum <= SW'(DEPTH - 2));
      HeadValid_IB_Sched[w] = (cnt_q[w] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NW; w++) begin
        rd_ptr_q[w] <= '0;
        wr_ptr_q[w] <= '0;
        cnt_q[w]    <= '0;
        for (int e = 0; e < DEPTH; e++) begin
          instr_mem_q[w][e] <= '0;
          dec_mem_q[w][e]   <= '0;
        end
      end
      valid_oc_q <= 1'b0;
      warp_oc_q  <= '0;
      instr_oc_q <= '0;
      dec_oc_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      instr_mem_q <= instr_mem_d;
      dec_mem_q   <= dec_mem_d;
      valid_oc_q  <= valid_oc_d;
      warp_oc_q   <= warp_oc_d;
      instr_oc_q  <= instr_oc_d;
      dec_oc_q    <= dec_oc_d;
      overflow_q  <= overflow_d;
    end
  end

  assign Valid_IB_OC  = valid_oc_q;
  assign WarpID_IB_OC = warp_oc_q;
  assign Instr_IB_OC  = instr_oc_q;
  assign Dec_IB_OC    = dec_oc_q;
  assign Overflow_IB  = overflow_q;

endmodule
